// File: rtl/boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader_pkg
// Description : Shared constants for the serial boot loader: FSM state
//               encoding, error codes, default frame marker, the lowest
//               loadable address and the address-range legality helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package boot_loader_pkg;

    // Everything below this word address belongs to the OS image and must
    // never be overwritten by a serial load.
    localparam logic [15:0] c_reserved_area     = 16'h1000;

    localparam logic [7:0]  c_sync_byte_default = 8'hA5;
    localparam logic [15:0] c_load_min_default  = c_reserved_area;

    // Frame parser states
    localparam logic [3:0] c_st_sync   = 4'd0;
    localparam logic [3:0] c_st_addr_h = 4'd1;
    localparam logic [3:0] c_st_addr_l = 4'd2;
    localparam logic [3:0] c_st_len_h  = 4'd3;
    localparam logic [3:0] c_st_len_l  = 4'd4;
    localparam logic [3:0] c_st_data_h = 4'd5;
    localparam logic [3:0] c_st_data_l = 4'd6;
    localparam logic [3:0] c_st_write  = 4'd7;
    localparam logic [3:0] c_st_csum   = 4'd8;
    localparam logic [3:0] c_st_done   = 4'd9;
    localparam logic [3:0] c_st_err    = 4'd10;

    // err_code values
    localparam logic [1:0] c_err_none     = 2'd0;
    localparam logic [1:0] c_err_bad_addr = 2'd1;
    localparam logic [1:0] c_err_overrun  = 2'd2;
    localparam logic [1:0] c_err_csum     = 2'd3;

    // A load is illegal if it starts inside the reserved area or if its last
    // word would land past 16'hFFFF. The end address is formed in 17 bits so
    // the carry out of the 16-bit sum is visible.
    function automatic logic range_bad(
        input logic [15:0] base,
        input logic [15:0] len,
        input logic [15:0] load_min
    );
        logic [16:0] last;
        last = {1'b0, base} + {1'b0, len} - 17'd1;
        return (base < load_min) || (last > 17'h0FFFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader
// Description : Serial boot loader. Parses a framed byte stream from the
//               SPART receiver (SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN
//               big-endian words, CSUM), writes each word to consecutive
//               word addresses through a stall-aware write handshake, holds
//               the processor in reset while loading and reports a sticky
//               done or coded error.
//
//               At the system level cpu_hold is ORed into the processor and
//               cache resets, and mem_* is muxed onto the cache data write
//               port while cpu_hold is high.
//
// Ports       : clk        in   system clock (50 MHz domain)
//               rst_n      in   synchronous active-low reset
//               rx_valid   in   one-cycle strobe, rx_data holds a byte
//               rx_data    in   received byte
//               mem_we     out  write request, held until mem_ack
//               mem_addr   out  word address of the current write
//               mem_wdata  out  write data
//               mem_ack    in   write accepted this cycle
//               cpu_hold   out  keep the processor in reset
//               busy       out  frame in progress
//               done       out  last frame completed (sticky)
//               err        out  last frame failed (sticky)
//               err_code   out  1 BAD_ADDR, 2 OVERRUN, 3 CSUM, 0 if no error
// Revision    : 1.0 - initial release
// ============================================================================
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = c_sync_byte_default,
    parameter logic [15:0] LOAD_MIN  = c_load_min_default
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]  r_state;
    logic [15:0] r_addr;       // base address, then the running write address
    logic [15:0] r_len;        // LEN_H during the header, then words remaining
    logic [7:0]  r_data_h;     // high byte of the word being assembled
    logic [7:0]  r_sum;        // running modulo-256 checksum
    logic        r_mem_we;
    logic [15:0] r_mem_wdata;
    logic        r_cpu_hold;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_err_code;

    logic        r_skid_full;
    logic [7:0]  r_skid_data;

    // ------------------------------------------------------------------
    // Byte source selection
    // ------------------------------------------------------------------
    logic        w_in_write;
    logic        w_rx_blocked;
    logic        w_use_skid;
    logic        w_byte_valid;
    logic [7:0]  w_byte;
    logic        w_overrun;
    logic [7:0]  w_sum_next;
    logic [15:0] w_len_full;
    logic        w_range_bad;

    assign w_in_write   = (r_state == c_st_write);

    // While writing, incoming bytes can only be parked in the skid register;
    // DONE and ERR ignore the receiver entirely.
    assign w_rx_blocked = w_in_write || (r_state == c_st_done) || (r_state == c_st_err);

    // A parked byte always has priority over a fresh one so ordering holds.
    assign w_use_skid   = r_skid_full && !w_rx_blocked;
    assign w_byte_valid = w_use_skid || (rx_valid && !w_rx_blocked);
    assign w_byte       = w_use_skid ? r_skid_data : rx_data;

    // Second byte while the single skid slot is still occupied by a write stall.
    assign w_overrun    = w_in_write && rx_valid && r_skid_full;

    assign w_sum_next   = r_sum + w_byte;
    assign w_len_full   = {r_len[7:0], w_byte};
    assign w_range_bad  = range_bad(r_addr, w_len_full, LOAD_MIN);

    // ------------------------------------------------------------------
    // Skid register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_skid_full <= 1'b0;
            r_skid_data <= 8'h00;
        end else if ((r_state == c_st_done) || (r_state == c_st_err)) begin
            // Frame is over; nothing parked may leak into the next one.
            r_skid_full <= 1'b0;
        end else if (w_in_write) begin
            if (rx_valid && !r_skid_full) begin
                r_skid_full <= 1'b1;
                r_skid_data <= rx_data;
            end
        end else if (w_use_skid) begin
            // Draining this cycle; a byte arriving now takes the freed slot.
            r_skid_full <= rx_valid;
            if (rx_valid) begin
                r_skid_data <= rx_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame parser / write sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_sync;
            r_addr      <= 16'h0000;
            r_len       <= 16'h0000;
            r_data_h    <= 8'h00;
            r_sum       <= 8'h00;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 16'h0000;
            r_cpu_hold  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= c_err_none;
        end else begin
            case (r_state)
                c_st_sync: begin
                    if (w_byte_valid && (w_byte == SYNC_BYTE)) begin
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_err_code <= c_err_none;
                        r_busy     <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_sum      <= 8'h00;
                        r_state    <= c_st_addr_h;
                    end
                end

                c_st_addr_h: begin
                    if (w_byte_valid) begin
                        r_addr[15:8] <= w_byte;
                        r_sum        <= w_sum_next;
                        r_state      <= c_st_addr_l;
                    end
                end

                c_st_addr_l: begin
                    if (w_byte_valid) begin
                        r_addr[7:0] <= w_byte;
                        r_sum       <= w_sum_next;
                        r_state     <= c_st_len_h;
                    end
                end

                c_st_len_h: begin
                    if (w_byte_valid) begin
                        r_len   <= {8'h00, w_byte};
                        r_sum   <= w_sum_next;
                        r_state <= c_st_len_l;
                    end
                end

                c_st_len_l: begin
                    if (w_byte_valid) begin
                        r_len <= w_len_full;
                        r_sum <= w_sum_next;
                        if (w_range_bad) begin
                            r_err      <= 1'b1;
                            r_err_code <= c_err_bad_addr;
                            r_busy     <= 1'b0;
                            r_state    <= c_st_err;
                        end else if (w_len_full == 16'h0000) begin
                            r_state <= c_st_csum;
                        end else begin
                            r_state <= c_st_data_h;
                        end
                    end
                end

                c_st_data_h: begin
                    if (w_byte_valid) begin
                        r_data_h <= w_byte;
                        r_sum    <= w_sum_next;
                        r_state  <= c_st_data_l;
                    end
                end

                c_st_data_l: begin
                    if (w_byte_valid) begin
                        r_mem_wdata <= {r_data_h, w_byte};
                        r_mem_we    <= 1'b1;
                        r_sum       <= w_sum_next;
                        r_state     <= c_st_write;
                    end
                end

                c_st_write: begin
                    if (w_overrun) begin
                        // The pending write is abandoned; earlier words stay.
                        r_mem_we   <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= c_err_overrun;
                        r_busy     <= 1'b0;
                        r_state    <= c_st_err;
                    end else if (mem_ack) begin
                        r_mem_we <= 1'b0;
                        r_addr   <= r_addr + 16'd1;
                        r_len    <= r_len - 16'd1;
                        r_state  <= (r_len == 16'd1) ? c_st_csum : c_st_data_h;
                    end
                end

                c_st_csum: begin
                    if (w_byte_valid) begin
                        if (w_byte == r_sum) begin
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_cpu_hold <= 1'b0;
                            r_state    <= c_st_done;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= c_err_csum;
                            r_busy     <= 1'b0;
                            r_state    <= c_st_err;
                        end
                    end
                end

                // Single-cycle terminal states; cpu_hold stays high after an
                // error so the processor cannot run a partial image.
                c_st_done: r_state <= c_st_sync;
                c_st_err:  r_state <= c_st_sync;

                default:   r_state <= c_st_sync;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = r_cpu_hold;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_boot_loader
// Description : Self-checking bench for boot_loader. Frames are expressed
//               as byte queues; the expected write list and outcome come
//               from a frame-level reference model (address range rule,
//               word list, modulo-256 checksum). A responder process models
//               the stalling write port and logs accepted writes.
// Ports       : none (testbench)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

    localparam logic [15:0] c_load_min = 16'h1000;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        mem_ack  = 1'b0;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int errors = 0;
    int checks = 0;

    logic [7:0]  frm[$];     // frame under test
    logic [31:0] exp_w[$];   // expected {addr, data} writes
    logic [31:0] got_w[$];   // observed {addr, data} writes

    int stall_cycles = 0;
    bit ack_rand     = 1'b0;

    boot_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write-port responder: ack after cur_stall cycles of mem_we high; logs
    // every write that will be accepted on the coming edge and checks that
    // address/data do not move while a request is pending.
    int          ack_cnt    = 0;
    int          cur_stall  = 0;
    bit          we_seen    = 1'b0;
    logic        prev_we    = 1'b0;
    logic [15:0] prev_addr  = 16'h0;
    logic [15:0] prev_wdata = 16'h0;

    always @(negedge clk) begin
        if (rst_n && mem_we && prev_we) begin
            chk("addr_stable", mem_addr, prev_addr);
            chk("wdata_stable", mem_wdata, prev_wdata);
        end
        prev_we    = mem_we && rst_n;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        if (mem_we) begin
            if (!we_seen) begin
                we_seen   = 1'b1;
                ack_cnt   = 0;
                cur_stall = ack_rand ? int'($urandom_range(0, 3)) : stall_cycles;
            end
            mem_ack = (ack_cnt >= cur_stall);
            ack_cnt++;
            if (mem_ack && rst_n) got_w.push_back({mem_addr, mem_wdata});
        end else begin
            we_seen = 1'b0;
            mem_ack = 1'b0;
        end
    end

    // Frame-level reference model: returns the expected err_code (0 = done)
    // and fills exp_w with the words that must reach memory.
    function automatic logic [1:0] model();
        int base;
        int len;
        int sum;
        exp_w.delete();
        base = int'({frm[1], frm[2]});
        len  = int'({frm[3], frm[4]});
        if (base < int'(c_load_min) || base + len - 1 > 65535) return 2'd1;
        for (int i = 0; i < len; i++)
            exp_w.push_back({16'(base + i), frm[5 + 2 * i], frm[6 + 2 * i]});
        sum = 0;
        for (int i = 1; i < frm.size() - 1; i++) sum += int'(frm[i]);
        return ((sum & 255) == int'(frm[$])) ? 2'd0 : 2'd3;
    endfunction

    task automatic append_csum();
        int sum;
        sum = 0;
        for (int i = 1; i < frm.size(); i++) sum += int'(frm[i]);
        frm.push_back(8'(sum));
    endtask

    // kind: 0 below reserved area, 1 runs past 16'hFFFF, 2 bad csum, 3 good
    task automatic build_random(input int kind);
        int len;
        int base;
        len = int'($urandom_range(0, 5));
        frm.delete();
        if (kind == 0) begin
            base = int'($urandom_range(0, 16'h0FFF));
        end else if (kind == 1) begin
            len  = int'($urandom_range(2, 5));
            base = 65536 - len + int'($urandom_range(1, len - 1));
        end else begin
            base = int'($urandom_range(16'h1000, 65536 - ((len == 0) ? 1 : len)));
        end
        frm.push_back(8'hA5);
        frm.push_back(8'(base >> 8));
        frm.push_back(8'(base));
        frm.push_back(8'(len >> 8));
        frm.push_back(8'(len));
        if (kind <= 1) return;
        for (int i = 0; i < 2 * len; i++) frm.push_back(8'($urandom_range(0, 255)));
        append_csum();
        if (kind == 2) frm[$] = frm[$] ^ 8'($urandom_range(1, 255));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int gap, input int force_code, input int first);
        logic [1:0] code;
        int n;
        got_w.delete();
        code = model();
        if (force_code >= 0) begin
            code = force_code[1:0];
            exp_w.delete();
        end
        for (int i = first; i < frm.size(); i++) begin
            send_byte(frm[i]);
            repeat (gap) @(negedge clk);
        end
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".timeout"}, 32'(n < 200), 32'd1);
        chk({tag, ".done"},     32'(done),     32'(code == 2'd0));
        chk({tag, ".err"},      32'(err),      32'(code != 2'd0));
        chk({tag, ".err_code"}, 32'(err_code), 32'(code));
        chk({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(code != 2'd0));
        chk({tag, ".busy"},     32'(busy),     32'd0);
        chk({tag, ".nwrites"},  32'(got_w.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            chk($sformatf("%s.w%0d", tag, i), got_w[i], exp_w[i]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".mem_we"},    32'(mem_we),    32'd0);
        chk({tag, ".mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, ".cpu_hold"},  32'(cpu_hold),  32'd1);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".done"},      32'(done),      32'd0);
        chk({tag, ".err"},       32'(err),       32'd0);
        chk({tag, ".err_code"},  32'(err_code),  32'd0);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Good frame at the lowest legal address
        frm = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        append_csum();
        run_frame("good", 2, -1, 0);

        // Base just below the reserved boundary
        frm = '{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h01};
        run_frame("low_addr", 2, -1, 0);

        // Last word would land at 0x10000
        frm = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02};
        run_frame("top_over", 2, -1, 0);

        // Single word at 0xFFFF is legal
        frm = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h11, 8'h22};
        append_csum();
        run_frame("top_edge", 2, -1, 0);

        // 5-cycle stall with exactly one byte arriving per write
        stall_cycles = 5;
        frm = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        append_csum();
        run_frame("skid", 3, -1, 0);

        // Two bytes during the first stalled write: nothing written
        run_frame("overrun", 0, 2, 0);
        stall_cycles = 0;

        // Bad checksum: words still land, processor stays held
        frm = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h33};
        run_frame("bad_csum", 2, -1, 0);

        // Junk outside a frame is discarded and leaves sticky flags alone
        send_byte(8'h00);
        send_byte(8'hFF);
        chk("junk.busy", 32'(busy), 32'd0);
        chk("junk.err_sticky", 32'(err), 32'd1);
        frm = '{8'hA5, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20};
        run_frame("zero_len", 2, -1, 0);

        // A new SYNC clears done and raises busy/cpu_hold immediately
        build_random(3);
        send_byte(frm[0]);
        chk("follow.done_clr", 32'(done), 32'd0);
        chk("follow.busy", 32'(busy), 32'd1);
        chk("follow.cpu_hold", 32'(cpu_hold), 32'd1);
        run_frame("follow", 2, -1, 1);

        // Reset while a write is pending
        stall_cycles = 100;
        got_w.delete();
        frm = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        append_csum();
        for (int i = 0; i < 7; i++) send_byte(frm[i]);
        repeat (2) @(negedge clk);
        chk("rst_mid.mem_we", 32'(mem_we), 32'd1);
        chk("rst_mid.mem_addr", 32'(mem_addr), 32'h1000);
        chk("rst_mid.mem_wdata", 32'(mem_wdata), 32'h1234);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("rst_mid");
        chk("rst_mid.nwrites", 32'(got_w.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stall_cycles = 0;
        run_frame("after_rst", 2, -1, 0);

        // Randomised frames with random write stalls
        ack_rand = 1'b1;
        for (int k = 0; k < 14; k++) begin
            int r;
            int kind;
            r = int'($urandom_range(0, 9));
            kind = (r == 0) ? 0 : (r == 1) ? 1 : (r <= 3) ? 2 : 3;
            build_random(kind);
            run_frame($sformatf("rnd%0d", k), int'($urandom_range(8, 12)), -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
